// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default bus widths and the
// slave-index width helper used by the master and the slave models.
package apb_pkg;

  localparam int DEFAULT_ADDR_W = 9;
  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  // Number of PADDR MSBs needed to index the slaves, never less than one.
  function automatic int sel_width(input int num_slaves);
    return (num_slaves <= 2) ? 1 : $clog2(num_slaves);
  endfunction

endpackage

// File: rtl/apb_decode.sv
// Slave index to one-hot select decoder; flags indices with no slave behind them.
module apb_decode #(
  parameter int NUM_SLAVES = 2,
  parameter int SEL_W      = 1
) (
  input  logic [SEL_W-1:0]      idx,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  decode_err
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    sel        = '0;
    decode_err = (int'(idx) >= NUM_SLAVES);
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (int'(idx) == i) sel[i] = 1'b1;
    end
  end

endmodule

// File: rtl/apb_master_mux.sv
// APB master with built-in N-way slave decode, response mux, decode-error
// detection and an ACCESS wait-state timeout.
module apb_master_mux
  import apb_pkg::*;
#(
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int NUM_SLAVES = 2,
  parameter int SEL_W      = sel_width(NUM_SLAVES),
  parameter int TIMEOUT    = 16
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [ADDR_W-1:0]            cmd_addr,
  input  logic [DATA_W-1:0]            cmd_wdata,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic [NUM_SLAVES-1:0]        PSEL,
  output logic                         PENABLE,
  output logic                         PWRITE,
  output logic [ADDR_W-1:0]            PADDR,
  output logic [DATA_W-1:0]            PWDATA,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA_bus,
  input  logic [NUM_SLAVES-1:0]        PREADY_vec,
  input  logic [NUM_SLAVES-1:0]        PSLVERR_vec
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W:0] TO_LIMIT = (CNT_W + 1)'(TIMEOUT);

  state_t                  state;
  logic                    dec_err;
  logic [CNT_W-1:0]        wait_cnt;
  logic [NUM_SLAVES-1:0]   sel_new;
  logic                    dec_err_new;
  logic                    ready_sel;
  logic                    slverr_sel;
  logic [DATA_W-1:0]       rdata_sel;
  logic [CNT_W:0]          cnt_next;
  logic                    timeout_hit;

  apb_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SEL_W      (SEL_W)
  ) u_decode (
    .idx        (cmd_addr[ADDR_W-1 -: SEL_W]),
    .sel        (sel_new),
    .decode_err (dec_err_new)
  );

  assign cmd_ready = (state == IDLE);

  // PSEL is one-hot (or zero), so masking with it picks the addressed slave.
  assign ready_sel  = |(PREADY_vec & PSEL);
  assign slverr_sel = |(PSLVERR_vec & PSEL);

  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (PSEL[i]) rdata_sel |= PRDATA_bus[i*DATA_W +: DATA_W];
    end
  end

  assign cnt_next    = {1'b0, wait_cnt} + (CNT_W + 1)'(1);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_next == TO_LIMIT);

  // NOTE: state and outputs are registers, so every assignment here is non-blocking.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= IDLE;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      dec_err   <= 1'b0;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            PADDR    <= cmd_addr;
            PWDATA   <= cmd_wdata;
            PWRITE   <= cmd_write;
            PSEL     <= sel_new;
            dec_err  <= dec_err_new;
            wait_cnt <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (dec_err || ready_sel) begin
            rsp_valid <= 1'b1;
            rsp_err   <= dec_err || slverr_sel;
            rsp_rdata <= (!PWRITE && !dec_err && !slverr_sel) ? rdata_sel : '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            state     <= IDLE;
          end else if (timeout_hit) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            state     <= IDLE;
          end else begin
            wait_cnt <= cnt_next[CNT_W-1:0];
          end
        end
        default: begin
          PSEL    <= '0;
          PENABLE <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_mux.sv
// Self-checking bench for apb_master_mux (3 slaves, timeout 4): directed
// scenarios followed by randomized transfers against a transaction-level model.
module tb_apb_master_mux;
  import apb_pkg::*;

  localparam int AW  = DEFAULT_ADDR_W;
  localparam int DW  = DEFAULT_DATA_W;
  localparam int NS  = 3;
  localparam int TO  = 4;
  localparam int SEL = (NS <= 2) ? 1 : $clog2(NS);

  logic           PCLK = 1'b0;
  logic           PRESET;
  logic           cmd_valid;
  logic           cmd_ready;
  logic           cmd_write;
  logic [AW-1:0]  cmd_addr;
  logic [DW-1:0]  cmd_wdata;
  logic           rsp_valid;
  logic [DW-1:0]  rsp_rdata;
  logic           rsp_err;
  logic [NS-1:0]  PSEL;
  logic           PENABLE;
  logic           PWRITE;
  logic [AW-1:0]  PADDR;
  logic [DW-1:0]  PWDATA;
  logic [NS*DW-1:0] PRDATA_bus;
  logic [NS-1:0]  PREADY_vec;
  logic [NS-1:0]  PSLVERR_vec;

  int checks = 0;
  int errors = 0;

  // Expected response of the last transfer, and what rsp_* must hold afterwards.
  bit            pending  = 1'b0;
  logic          exp_err  = 1'b0;
  logic [DW-1:0] exp_rdata = '0;

  apb_master_mux #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .NUM_SLAVES (NS),
    .TIMEOUT    (TO)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PRDATA_bus  (PRDATA_bus),
    .PREADY_vec  (PREADY_vec),
    .PSLVERR_vec (PSLVERR_vec)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic junk_slaves();
    PREADY_vec  = NS'($urandom);
    PSLVERR_vec = NS'($urandom);
    PRDATA_bus  = (NS*DW)'($urandom);
  endtask

  task automatic step();
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  // Called at every negedge where the master should be idle.
  task automatic check_rsp();
    if (pending) begin
      check("rsp_valid", rsp_valid, 1);
      check("rsp_err", rsp_err, exp_err);
      check("rsp_rdata", rsp_rdata, exp_rdata);
      check("psel_done", PSEL, 0);
      check("penable_done", PENABLE, 0);
      pending = 1'b0;
    end else begin
      check("rsp_valid_pulse", rsp_valid, 0);
      check("rsp_err_hold", rsp_err, exp_err);
      check("rsp_rdata_hold", rsp_rdata, exp_rdata);
    end
    check("cmd_ready_idle", cmd_ready, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      check_rsp();
      cmd_valid = 1'b0;
      cmd_addr  = AW'($urandom);
      junk_slaves();
      step();
    end
  endtask

  // One transfer; waits = ACCESS cycles with PREADY low before the target slave answers.
  task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                      input int waits, input logic [DW-1:0] sdata, input logic serr);
    int            idx;
    bit            derr;
    bit            tmo;
    int            n_acc;
    logic [NS-1:0] exp_psel;
    idx      = int'(addr >> (AW - SEL));
    derr     = (idx >= NS);
    exp_psel = derr ? '0 : NS'(1 << idx);
    tmo      = !derr && (TO > 0) && (waits >= TO);
    n_acc    = derr ? 1 : (tmo ? TO : waits + 1);

    check_rsp();
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    junk_slaves();
    step();

    check("setup_psel", PSEL, exp_psel);
    check("setup_penable", PENABLE, 0);
    check("setup_paddr", PADDR, addr);
    check("setup_pwrite", PWRITE, wr);
    check("setup_pwdata", PWDATA, wdata);
    check("setup_rsp_valid", rsp_valid, 0);
    check("setup_cmd_ready", cmd_ready, 0);
    cmd_valid = 1'($urandom);
    cmd_write = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_wdata = DW'($urandom);
    junk_slaves();
    step();

    for (int k = 0; k < n_acc; k++) begin
      check("access_psel", PSEL, exp_psel);
      check("access_penable", PENABLE, 1);
      check("access_paddr", PADDR, addr);
      check("access_pwrite", PWRITE, wr);
      check("access_pwdata", PWDATA, wdata);
      check("access_rsp_valid", rsp_valid, 0);
      junk_slaves();
      if (!derr) begin
        PREADY_vec[idx]          = (k == waits);
        PSLVERR_vec[idx]         = serr;
        PRDATA_bus[idx*DW +: DW] = sdata;
      end
      step();
    end

    pending   = 1'b1;
    exp_err   = derr || tmo || serr;
    exp_rdata = (!wr && !exp_err) ? sdata : '0;
  endtask

  initial begin
    PRESET    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    junk_slaves();
    repeat (2) @(negedge PCLK);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    PRESET = 1'b0;
    idle(2);

    // Write to slave 2 with no wait states.
    xfer(1'b1, 9'h105, 8'hA5, 0, 8'h00, 1'b0);
    idle(1);
    // Read slave 0 with two wait states.
    xfer(1'b0, 9'h012, 8'h00, 2, 8'h3C, 1'b0);
    idle(1);
    // Index 3 has no slave: decode error.
    xfer(1'b0, 9'h1C0, 8'h00, 0, 8'h77, 1'b0);
    idle(1);
    // Slave never ready: timeout after TO ACCESS cycles.
    xfer(1'b0, 9'h080, 8'h00, 100, 8'h55, 1'b0);
    idle(1);
    // Ready on the last allowed ACCESS cycle wins over the timeout.
    xfer(1'b0, 9'h081, 8'h00, TO - 1, 8'h5A, 1'b0);
    idle(1);
    // Slave error on a read squashes the read data.
    xfer(1'b0, 9'h0A0, 8'h00, 0, 8'hFF, 1'b1);
    idle(1);
    // Back-to-back write then read: the second accept lands on the first rsp_valid.
    xfer(1'b1, 9'h0C3, 8'h3E, 0, 8'h00, 1'b0);
    xfer(1'b0, 9'h150, 8'h00, 0, 8'h96, 1'b0);
    idle(2);

    // Reset while in ACCESS: bus drops at once and no response is produced.
    check_rsp();
    cmd_valid   = 1'b1;
    cmd_write   = 1'b0;
    cmd_addr    = 9'h005;
    PREADY_vec  = '0;
    PSLVERR_vec = '0;
    step();
    cmd_valid = 1'b0;
    step();
    check("pre_rst_penable", PENABLE, 1);
    check("pre_rst_psel", PSEL, 3'b001);
    step();
    PRESET = 1'b1;
    #1;
    check("midrst_psel", PSEL, 0);
    check("midrst_penable", PENABLE, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_rsp_valid", rsp_valid, 0);
    @(negedge PCLK);
    PRESET    = 1'b0;
    pending   = 1'b0;
    exp_err   = 1'b0;
    exp_rdata = '0;
    idle(3);

    // Randomized transfers, some back-to-back, some with idle gaps.
    for (int n = 0; n < 60; n++) begin
      xfer(1'($urandom), AW'($urandom), DW'($urandom), int'($urandom_range(0, 6)),
           DW'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
